// File: rtl/drum_pkg.sv
// Shared types and fixed widths for the drum-mesh sample sequencer.
package drum_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOOT,
    S_SETTLE,
    S_CAPTURE,
    S_PUSH
  } state_t;

  localparam int NODE_W     = 18;
  localparam int AUDIO_W    = 16;
  localparam int FRAC_SHIFT = 2;
endpackage

// File: rtl/node_to_audio_sat.sv
// Converts a signed 1.17 node value to signed 1.15 audio with gain and clamping.
module node_to_audio_sat #(
  parameter int NODE_W  = 18,
  parameter int AUDIO_W = 16
) (
  input  logic signed [NODE_W-1:0]  node,
  input  logic        [2:0]         gain_shift,
  output logic signed [AUDIO_W-1:0] audio
);
  import drum_pkg::*;

  // Eight guard bits cover the largest gain shift without overflow.
  localparam int EXT_W = NODE_W + 8;
  localparam logic signed [EXT_W-1:0] AUDIO_MAX = EXT_W'((2 ** (AUDIO_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] AUDIO_MIN = -AUDIO_MAX - EXT_W'(1);

  function automatic logic signed [AUDIO_W-1:0] sat_audio(input logic signed [EXT_W-1:0] v);
    if (v > AUDIO_MAX)      return AUDIO_MAX[AUDIO_W-1:0];
    else if (v < AUDIO_MIN) return AUDIO_MIN[AUDIO_W-1:0];
    else                    return v[AUDIO_W-1:0];
  endfunction

  logic signed [EXT_W-1:0] ext;
  logic signed [EXT_W-1:0] scaled;

  always_comb begin
    ext    = EXT_W'(node);
    scaled = (ext <<< gain_shift) >>> FRAC_SHIFT;
    audio  = sat_audio(scaled);
  end
endmodule

// File: rtl/drum_sample_sequencer.sv
// Per-sample timing master: fires the column solvers, waits for them to settle,
// captures the centre node and hands a saturated audio sample downstream.
module drum_sample_sequencer #(
  parameter int CLK_PER_SAMPLE = 1042,
  parameter int SETTLE_CYCLES  = 64,
  parameter int NODE_W         = 18,
  parameter int AUDIO_W        = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic        [2:0]         gain_shift,
  input  logic signed [NODE_W-1:0]  output_node,
  output logic                      shoot,
  output logic signed [AUDIO_W-1:0] audio_data,
  output logic                      audio_valid,
  input  logic                      audio_ready,
  output logic        [15:0]        sample_count,
  output logic        [15:0]        overrun_count
);
  import drum_pkg::*;

  localparam int TICK_W = $clog2(CLK_PER_SAMPLE);
  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(CLK_PER_SAMPLE - 1);
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  state_t                    state;
  logic [TICK_W-1:0]         tick_cnt;
  logic [SET_W-1:0]          settle_cnt;
  logic                      tick;
  logic [15:0]               overrun_nxt;
  logic signed [AUDIO_W-1:0] sat_sample;

  assign tick = (tick_cnt == TICK_LAST);

  node_to_audio_sat #(
    .NODE_W (NODE_W),
    .AUDIO_W(AUDIO_W)
  ) u_sat (
    .node      (output_node),
    .gain_shift(gain_shift),
    .audio     (sat_sample)
  );

  // Any tick that cannot start a timestep is lost, including the handshake cycle.
  always_comb begin
    overrun_nxt = overrun_count;
    if (tick && (state != S_IDLE) && (overrun_count != 16'hFFFF))
      overrun_nxt = overrun_count + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      tick_cnt      <= '0;
      settle_cnt    <= '0;
      shoot         <= 1'b0;
      audio_valid   <= 1'b0;
      audio_data    <= '0;
      sample_count  <= '0;
      overrun_count <= '0;
    end else begin
      tick_cnt      <= tick ? '0 : tick_cnt + 1'b1;
      overrun_count <= overrun_nxt;
      shoot         <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tick && enable) begin
            shoot <= 1'b1;
            state <= S_SHOOT;
          end
        end
        S_SHOOT: begin
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt == SETTLE_LAST) state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          audio_data  <= sat_sample;
          audio_valid <= 1'b1;
          state       <= S_PUSH;
        end
        S_PUSH: begin
          // Stalling here freezes the solvers: no new shoot until accepted.
          if (audio_ready) begin
            audio_valid  <= 1'b0;
            sample_count <= sample_count + 16'd1;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drum_sample_sequencer.sv
// Randomized and directed bench for drum_sample_sequencer against a timeline model.
module tb_drum_sample_sequencer;
  localparam int P = 100;
  localparam int S = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [2:0]        gain_shift = '0;
  logic signed [17:0] output_node = '0;
  logic              shoot;
  logic [15:0]       audio_data;
  logic              audio_valid;
  logic              audio_ready = 1'b1;
  logic [15:0]       sample_count;
  logic [15:0]       overrun_count;

  logic signed [17:0] sat_node = '0;
  logic [2:0]         sat_gs = '0;
  logic [15:0]        sat_out;

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  // Model: position in the sample period, age of the current timestep since its shoot.
  int          m_tcnt = 0;
  int          m_age = -1;
  int          m_scount = 0;
  int          m_ocount = 0;
  logic [15:0] m_data = '0;

  always #5 clk = ~clk;

  drum_sample_sequencer #(
    .CLK_PER_SAMPLE(P),
    .SETTLE_CYCLES (S),
    .NODE_W        (18),
    .AUDIO_W       (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .gain_shift   (gain_shift),
    .output_node  (output_node),
    .shoot        (shoot),
    .audio_data   (audio_data),
    .audio_valid  (audio_valid),
    .audio_ready  (audio_ready),
    .sample_count (sample_count),
    .overrun_count(overrun_count)
  );

  node_to_audio_sat #(
    .NODE_W (18),
    .AUDIO_W(16)
  ) sat_u (
    .node      (sat_node),
    .gain_shift(sat_gs),
    .audio     (sat_out)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_sat(input logic signed [17:0] n, input logic [2:0] g);
    int v;
    v = int'(n) * (1 << g);
    v = v >>> 2;
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic step();
    logic        r, en, rd;
    logic [15:0] capv;
    bit          tick, busy, push;
    r = rst_n; en = enable; rd = audio_ready;
    capv = ref_sat(output_node, gain_shift);
    @(posedge clk);
    #1;
    if (!r) begin
      m_tcnt = 0; m_age = -1; m_scount = 0; m_ocount = 0; m_data = '0;
      cyc = 0;
    end else begin
      tick = (m_tcnt == P - 1);
      busy = (m_age >= 0);
      push = (m_age >= S + 2);
      if (tick && busy && m_ocount < 65535) m_ocount++;
      if (m_age == S + 1) m_data = capv;
      if (push && rd) begin
        m_age = -1;
        m_scount = (m_scount + 1) % 65536;
      end else if (busy) begin
        if (!push) m_age++;
      end else if (tick && en) begin
        m_age = 0;
      end
      m_tcnt = tick ? 0 : m_tcnt + 1;
      cyc++;
    end
    check_val("shoot", 32'(shoot), 32'(m_age == 0));
    check_val("valid", 32'(audio_valid), 32'(m_age >= S + 2));
    check_val("data", 32'(audio_data), 32'(m_data));
    check_val("sample_count", 32'(sample_count), m_scount);
    check_val("overrun_count", 32'(overrun_count), m_ocount);
  endtask

  task automatic run_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_val("rst_shoot", 32'(shoot), 32'd0);
    check_val("rst_valid", 32'(audio_valid), 32'd0);
    check_val("rst_data", 32'(audio_data), 32'd0);
    check_val("rst_sc", 32'(sample_count), 32'd0);
    check_val("rst_oc", 32'(overrun_count), 32'd0);

    // Cadence with a full-scale positive node
    enable = 1'b1; audio_ready = 1'b1;
    output_node = 18'sh1FFFF; gain_shift = 3'd2;
    run_to(100);
    check_val("cad_shoot100", 32'(shoot), 32'd1);
    run_to(112);
    check_val("cad_valid112", 32'(audio_valid), 32'd1);
    check_val("cad_data_pos", 32'(audio_data), 32'h7FFF);
    run_to(313);
    check_val("cad_sc3", 32'(sample_count), 32'd3);

    // Stand-alone conversion corners and random points
    sat_node = 18'sh1FFFF; sat_gs = 3'd2; #1;
    check_val("sat_pos", 32'(sat_out), 32'h7FFF);
    sat_node = -18'sd131072; sat_gs = 3'd2; #1;
    check_val("sat_neg", 32'(sat_out), 32'h8000);
    sat_node = 18'sd4; sat_gs = 3'd0; #1;
    check_val("sat_p4", 32'(sat_out), 32'h0001);
    sat_node = -18'sd4; sat_gs = 3'd0; #1;
    check_val("sat_m4", 32'(sat_out), 32'hFFFF);
    for (int i = 0; i < 200; i++) begin
      sat_node = 18'($urandom); sat_gs = 3'($urandom); #1;
      check_val("sat_rand", 32'(sat_out), 32'(ref_sat(sat_node, sat_gs)));
    end

    // Backpressure across a tick
    do_reset();
    enable = 1'b1; audio_ready = 1'b1; output_node = -18'sd131072; gain_shift = 3'd2;
    run_to(110);
    audio_ready = 1'b0;
    run_to(261);
    check_val("bp_oc1", 32'(overrun_count), 32'd1);
    check_val("bp_data_neg", 32'(audio_data), 32'h8000);
    audio_ready = 1'b1;
    run_to(300);
    check_val("bp_shoot300", 32'(shoot), 32'd1);
    run_to(320);

    // Enable dropped during settle
    do_reset();
    enable = 1'b1; audio_ready = 1'b1; output_node = 18'sd4; gain_shift = 3'd0;
    run_to(105);
    enable = 1'b0;
    run_to(320);
    check_val("en_sc1", 32'(sample_count), 32'd1);
    check_val("en_oc0", 32'(overrun_count), 32'd0);

    // Reset while a sample is waiting
    do_reset();
    enable = 1'b1; audio_ready = 1'b0;
    run_to(115);
    check_val("rp_valid_pre", 32'(audio_valid), 32'd1);
    do_reset();
    check_val("rp_valid_post", 32'(audio_valid), 32'd0);
    audio_ready = 1'b1;
    run_to(100);
    check_val("rp_shoot100", 32'(shoot), 32'd1);
    run_to(120);

    // Randomized traffic
    begin
      int rdy_pct;
      rdy_pct = 50;
      for (int i = 0; i < 20000; i++) begin
        if (i % 997 == 0) rdy_pct = ($urandom % 3 == 0) ? 2 : 30 + int'($urandom % 71);
        enable      = ($urandom % 8) != 0;
        audio_ready = int'($urandom % 100) < rdy_pct;
        output_node = 18'($urandom);
        gain_shift  = 3'($urandom);
        rst_n       = ($urandom % 4000) != 0;
        step();
      end
      rst_n = 1'b1;
    end

    // Overrun counter saturation
    do_reset();
    enable = 1'b1; audio_ready = 1'b0;
    run_to(150);
    force dut.overrun_count = 16'hFFFE;
    m_ocount = 65534;
    step();
    release dut.overrun_count;
    run_to(310);
    check_val("ovr_sat", 32'(overrun_count), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/drum_sample_sequencer.md
Name: drum_sample_sequencer

Overview:
- Per-audio-sample timing master for the drum mesh.
- Generates the one-cycle `shoot` pulse that releases every column solver for one timestep.
- Waits a fixed settle window for the column pass to finish, then captures the column's centre-node value (`output_node`, signed 1.17).
- Scales and saturates that value to 16-bit audio and presents it on a valid/ready interface to the audio output path. Counts dropped sample ticks (overruns).

Parameters:
- CLK_PER_SAMPLE, 1042, clocks per audio sample (50 MHz / 48 kHz); must exceed SETTLE_CYCLES+4.
- SETTLE_CYCLES, 64, cycles between the `shoot` pulse and capture; must be at least 2*R+2 of the column solver (R=30 gives at least 62).
- NODE_W, 18, width of the node value.
- AUDIO_W, 16, width of the audio sample.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  allows new timesteps to start.
- gain_shift  in  3  left-shift applied before saturation (0..7).
- output_node  in  18  signed centre-node value from the column solver.
- shoot  out  1  one-cycle pulse: column solvers begin a timestep.
- audio_data  out  16  signed audio sample.
- audio_valid  out  1  audio_data is valid.
- audio_ready  in  1  downstream accepts the sample.
- sample_count  out  16  samples delivered; wraps at 16'hFFFF to 0.
- overrun_count  out  16  ticks dropped; saturates at 16'hFFFF.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=S_IDLE, tick_cnt=0, settle_cnt=0.
  - shoot=0, audio_valid=0, audio_data=0, sample_count=0, overrun_count=0.
  - Reset mid-operation abandons any pending sample; no partial `shoot`.
- Tick counter:
  - Free-runs 0..CLK_PER_SAMPLE-1, independent of state and enable.
  - tick=1 while tick_cnt==CLK_PER_SAMPLE-1; the counter wraps to 0 on the next clock.
  - First tick after reset arrives at cycle CLK_PER_SAMPLE-1, leaving the column solvers time to finish their initial load/pass.
- Outputs: shoot, audio_valid and audio_data are Moore/registered; no combinational path from audio_ready or output_node to any output.
- States:
  - S_IDLE: tick && enable -> S_SHOOT; otherwise stay.
  - S_SHOOT: shoot=1 for exactly this cycle; settle_cnt<=0; -> S_SETTLE.
  - S_SETTLE: settle_cnt increments; at settle_cnt==SETTLE_CYCLES-1 -> S_CAPTURE.
  - S_CAPTURE: audio_data<=sat(output_node); -> S_PUSH.
  - S_PUSH: audio_valid=1, audio_data held stable. On audio_valid && audio_ready: sample_count++, go to S_IDLE with audio_valid dropping next cycle.
- Latency:
  - `shoot` is high the cycle after tick.
  - audio_valid rises SETTLE_CYCLES+2 cycles after `shoot`.
- Conversion (sat):
  - Sign-extend to 26 bits, arithmetic shift left by gain_shift, then arithmetic shift right by 2 (1.17 to 1.15).
  - Clamp to [-32768, 32767].
  - gain_shift is sampled in S_CAPTURE only.
- Overrun:
  - tick in any state other than S_IDLE, including the handshake cycle of S_PUSH, is dropped and overrun_count++ (saturating).
  - A tick in S_IDLE with enable=0 is not an overrun.
- Enable:
  - Deassertion mid-sample does not abort; the sample completes through its handshake, then the block stays in S_IDLE.
  - Re-enable waits for the next tick.
- Backpressure: unbounded stall in S_PUSH is legal; no further `shoot` is issued until the handshake completes, so the solvers stay frozen.

Decomposition:
- Package drum_pkg holds:
  - the state enum (S_IDLE, S_SHOOT, S_SETTLE, S_CAPTURE, S_PUSH);
  - localparams NODE_W=18, AUDIO_W=16, FRAC_SHIFT=2.
- One combinational sub-module, node_to_audio_sat (node in, gain_shift in, audio out), implements the shift-and-clamp so it can be unit-tested alone.

Test Plan:
- Cadence: CLK_PER_SAMPLE=100, SETTLE_CYCLES=10, enable=1, audio_ready=1 -> shoot high at cycles 100, 200, 300; audio_valid high for 1 cycle at 112, 212; sample_count=3 after cycle 312.
- Saturation: gain_shift=2 with output_node=18'h1FFFF -> audio_data=16'h7FFF; output_node=-131072 -> 16'h8000. gain_shift=0 with output_node=18'h00004 -> 16'h0001; with output_node=-4 -> 16'hFFFF.
- Backpressure: audio_ready=0 from cycle 110 to 260 -> audio_valid and audio_data stable throughout; no shoot at 200; overrun_count=1. After ready=1, next shoot at 300.
- Enable drop: enable=0 at cycle 105 (in S_SETTLE) -> sample still delivered at 112; no shoot at 200 or 300; overrun_count stays 0.
- Reset mid-PUSH: rst_n=0 for one cycle while audio_valid=1 -> next cycle audio_valid=0, shoot=0, sample_count=0, overrun_count=0; first new shoot exactly 100 cycles after reset release.
- Overrun saturation: force overrun_count to 16'hFFFF via repeated stalls (or bind-force) -> a further dropped tick leaves it at 16'hFFFF.
